pixel_sink: RTL and testbench



---
 rtl/fb_pkg.sv | 31 +++
 rtl/pixel_fifo.sv | 51 +++++
 rtl/pixel_sink.sv | 152 +++++++++++++++
 tb/tb_pixel_sink.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer definitions for the drawing pipeline.
//   color_t       - 3-bit pixel color
//   SCREEN_W/H    - default visible resolution
//   FB_ADDR_W     - default linear frame-buffer address width
//   COORD_W       - width of the x/y coordinates produced by the drawers
//   sink_state_t  - pixel_sink control states
//   pixel_t       - one queued pixel write (x, y, color)
package fb_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FB_ADDR_W = 19;
    localparam int COORD_W   = 11;

    typedef logic [2:0] color_t;

    // RUN: accept and write pixels. DRAIN: clear requested, flushing queued
    // pixels. CLEAR: full-screen fill sweep.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } sink_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        color_t             color;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: small synchronous FIFO with first-word-fall-through read data.
//   clk, reset_n  - clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata   - write request and data; ignored while full
//   pop           - read request; ignored while empty
//   rdata         - head entry, valid whenever !empty
//   full, empty   - occupancy flags
module pixel_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rdata = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and a reset-free array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/pixel_sink.sv
// pixel_sink: consumer end of the drawers' pixel stream.
//   clk, reset_n        - clock, asynchronous active-low reset
//   pix_valid/pix_ready - pixel handshake; x, y, color carry the pixel
//   clear_req           - one-cycle full-screen clear request
//   clear_color         - fill color, sampled with clear_req
//   fb_stall            - frame buffer busy; current write is held
//   fb_we/fb_addr/fb_data - registered frame-buffer write port
//   busy                - work queued, write pending, or clear active
//   clip_count          - saturating count of discarded off-screen pixels
// Pixels are queued in a FIFO, clipped, converted to linear addresses
// (y*WIDTH + x) and written one per cycle. A clear first drains queued
// pixels, then sweeps every address with the latched fill color.
module pixel_sink
    import fb_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    input  logic [2:0]        color,
    input  logic              clear_req,
    input  logic [2:0]        clear_color,
    input  logic              fb_stall,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_data,
    output logic              busy,
    output logic [15:0]       clip_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    sink_state_t       state;
    color_t            clr_color;
    pixel_t            in_pix;
    pixel_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              loadable;
    logic              on_screen;
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] pix_addr;

    // No pop-aware bypass: a full FIFO refuses input even if it pops this cycle.
    assign pix_ready = !fifo_full && (state == RUN);
    assign push      = pix_valid && pix_ready;
    assign in_pix    = '{x: x, y: y, color: color};

    // The output register may take a new value unless it holds a stalled write.
    assign loadable  = !fb_we || !fb_stall;
    assign pop       = (state != CLEAR) && !fifo_empty && loadable;

    assign busy      = !fifo_empty || fb_we || (state != RUN);

    pixel_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(pixel_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (in_pix),
        .pop     (pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign x_ext = ADDR_W'(head.x);
    assign y_ext = ADDR_W'(head.y);

    // NOTE: every output of a combinational block gets a value before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        pix_addr  = '0;
        on_screen = (32'(head.x) < WIDTH) && (32'(head.y) < HEIGHT);
        if (WIDTH == 640) begin
            // y*640 = y*512 + y*128
            pix_addr = (y_ext << 9) + (y_ext << 7) + x_ext;
        end else begin
            pix_addr = y_ext * ADDR_W'(WIDTH) + x_ext;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            clr_color  <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            clip_count <= '0;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    if (pop) begin
                        if (on_screen) begin
                            fb_we   <= 1'b1;
                            fb_addr <= pix_addr;
                            fb_data <= head.color;
                        end else begin
                            fb_we <= 1'b0;
                            if (clip_count != 16'hFFFF) begin
                                clip_count <= clip_count + 16'd1;
                            end
                        end
                    end else if (loadable) begin
                        fb_we <= 1'b0;
                    end

                    if (state == RUN && clear_req) begin
                        clr_color <= clear_color;
                        state     <= DRAIN;
                    end

                    // Last queued write has left the register: the first sweep
                    // write overrides the idle load above in the same edge.
                    if (state == DRAIN && fifo_empty && loadable) begin
                        state   <= CLEAR;
                        fb_we   <= 1'b1;
                        fb_addr <= '0;
                        fb_data <= clr_color;
                    end
                end

                CLEAR: begin
                    if (!fb_stall) begin
                        if (fb_addr == LAST_ADDR) begin
                            fb_we <= 1'b0;
                            state <= RUN;
                        end else begin
                            fb_addr <= fb_addr + ADDR_W'(1);
                        end
                    end
                end

                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_sink.sv
// tb_pixel_sink: directed scoreboard bench for pixel_sink. Two instances are
// used: the default 640x480 screen and a reduced 8x4 screen for clear sweeps.
// A select signal routes the shared stimulus to one instance and its outputs
// to the monitor.
module tb_pixel_sink;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic        pix_valid = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic [2:0]  color = '0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_color = '0;
    logic        fb_stall = 1'b0;

    logic        ready0, we0, busy0, ready1, we1, busy1;
    logic [18:0] addr0, addr1;
    logic [2:0]  data0, data1;
    logic [15:0] clip0, clip1;

    logic        m_ready, m_we, m_busy;
    logic [18:0] m_addr;
    logic [2:0]  m_data;
    logic [15:0] m_clip;

    typedef struct {
        logic [18:0] addr;
        logic [2:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    pixel_sink u_dut0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_valid   (pix_valid && !sel),
        .pix_ready   (ready0),
        .x           (x),
        .y           (y),
        .color       (color),
        .clear_req   (clear_req && !sel),
        .clear_color (clear_color),
        .fb_stall    (fb_stall),
        .fb_we       (we0),
        .fb_addr     (addr0),
        .fb_data     (data0),
        .busy        (busy0),
        .clip_count  (clip0)
    );

    pixel_sink #(
        .WIDTH  (8),
        .HEIGHT (4),
        .DEPTH  (4),
        .ADDR_W (19)
    ) u_dut1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_valid   (pix_valid && sel),
        .pix_ready   (ready1),
        .x           (x),
        .y           (y),
        .color       (color),
        .clear_req   (clear_req && sel),
        .clear_color (clear_color),
        .fb_stall    (fb_stall),
        .fb_we       (we1),
        .fb_addr     (addr1),
        .fb_data     (data1),
        .busy        (busy1),
        .clip_count  (clip1)
    );

    assign m_ready = sel ? ready1 : ready0;
    assign m_we    = sel ? we1    : we0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_addr  = sel ? addr1  : addr0;
    assign m_data  = sel ? data1  : data0;
    assign m_clip  = sel ? clip1  : clip0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write the frame buffer accepts must match the queue head.
    always @(negedge clk) begin
        if (reset_n && m_we && !fb_stall) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         m_addr, m_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(m_addr), 32'(e.addr));
                check("write_data", 32'(m_data), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pixel and wait (bounded) for it to be accepted.
    task automatic send(input int px, input int py, input logic [2:0] c,
                        input bit on, input int addr);
        int n;
        wr_t e;
        n = 0;
        pix_valid = 1'b1;
        x = px[10:0];
        y = py[10:0];
        color = c;
        @(negedge clk);
        while (!m_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("send_accepted", 32'(m_ready), 32'd1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        if (on) begin
            e.addr = addr[18:0];
            e.data = c;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (m_busy && n < budget) begin
            n++;
            @(negedge clk);
        end
        check("idle_reached", 32'(m_busy), 32'd0);
        tick();
    endtask

    task automatic queue_clear(input logic [2:0] c);
        wr_t e;
        for (int i = 0; i < 32; i++) begin
            e.addr = 19'(i);
            e.data = c;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int we_cnt;
        int busy_cnt;
        wr_t e;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_we", 32'(m_we), 32'd0);
        check("rst_addr", 32'(m_addr), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_clip", 32'(m_clip), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_ready", 32'(m_ready), 32'd1);
        tick();

        // Single pixel with 2-edge latency
        send(5, 2, 3'b101, 1'b1, 1285);
        @(negedge clk);
        check("latency_we_low", 32'(m_we), 32'd0);
        @(negedge clk);
        check("latency_we_high", 32'(m_we), 32'd1);
        wait_idle(20);
        check("single_busy_low", 32'(m_busy), 32'd0);

        // Clipping and the bottom-right corner
        send(640, 0, 3'b001, 1'b0, 0);
        send(0, 480, 3'b010, 1'b0, 0);
        wait_idle(20);
        check("clip_two", 32'(m_clip), 32'd2);
        send(639, 479, 3'b011, 1'b1, 307199);
        wait_idle(20);
        check("corner_queue_empty", exp_q.size(), 32'd0);

        // Stall capacity: FIFO plus output register
        fb_stall = 1'b1;
        acc = 0;
        pix_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x = 11'(10 + acc);
            y = 11'd1;
            color = 3'(acc);
            @(negedge clk);
            if (m_ready) begin
                e.addr = 19'(650 + acc);
                e.data = 3'(acc);
                exp_q.push_back(e);
                acc++;
            end
            tick();
        end
        pix_valid = 1'b0;
        check("stall_accepted", acc, 32'd5);
        repeat (2) begin
            @(negedge clk);
            check("stall_ready_low", 32'(m_ready), 32'd0);
            check("stall_we_held", 32'(m_we), 32'd1);
            check("stall_addr_held", 32'(m_addr), 32'd650);
            check("stall_data_held", 32'(m_data), 32'd0);
        end
        tick();
        fb_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("burst_we", 32'(m_we), 32'd1);
        end
        @(negedge clk);
        check("burst_done", 32'(m_we), 32'd0);
        wait_idle(20);
        check("burst_queue_empty", exp_q.size(), 32'd0);

        // Reduced 8x4 screen
        sel = 1'b1;
        tick();
        send(8, 0, 3'b001, 1'b0, 0);
        wait_idle(20);
        check("small_clip", 32'(m_clip), 32'd1);

        // Plain clear sweep
        clear_color = 3'b010;
        clear_req = 1'b1;
        queue_clear(3'b010);
        tick();
        clear_req = 1'b0;
        we_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!m_busy) break;
            busy_cnt++;
            if (m_we) we_cnt++;
            check("clear_ready_low", 32'(m_ready), 32'd0);
        end
        check("clear_writes", we_cnt, 32'd32);
        check("clear_busy_cycles", busy_cnt, 32'd33);
        check("clear_queue_empty", exp_q.size(), 32'd0);
        tick();

        // Queued pixels drain before the sweep; a second request is ignored
        fb_stall = 1'b1;
        send(1, 0, 3'b001, 1'b1, 1);
        send(2, 1, 3'b011, 1'b1, 10);
        send(7, 3, 3'b110, 1'b1, 31);
        clear_color = 3'b100;
        clear_req = 1'b1;
        queue_clear(3'b100);
        tick();
        clear_req = 1'b0;
        @(negedge clk);
        check("drain_ready_low", 32'(m_ready), 32'd0);
        check("drain_busy", 32'(m_busy), 32'd1);
        repeat (3) tick();
        fb_stall = 1'b0;
        repeat (10) tick();
        clear_color = 3'b111;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle(100);
        check("drain_queue_empty", exp_q.size(), 32'd0);

        // Reset in the middle of a sweep
        clear_color = 3'b101;
        clear_req = 1'b1;
        queue_clear(3'b101);
        tick();
        clear_req = 1'b0;
        repeat (6) tick();
        check("sweep_running", 32'(m_we), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_we_low", 32'(m_we), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(m_busy), 32'd0);
        check("post_rst_ready", 32'(m_ready), 32'd1);
        check("post_rst_clip", 32'(m_clip), 32'd0);
        check("post_rst_we", 32'(m_we), 32'd0);
        repeat (5) tick();
        check("post_rst_no_writes", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
